bcd_serial_subtractor: RTL and testbench
========================================

// Module: bcd_serial_subtractor
// PURPOSE
//   Digit-serial BCD subtractor: computes D = A - B - Bin over NDIGITS packed BCD
//   digits, one digit per clock, least-significant digit first.
//   Inverse arithmetic companion to the combinational BCD adder datapath.
//   Sits beside the adder in the decimal ALU path.
//   Start/busy/done handshake; result held stable until the next accepted start.
// PARAMETERS
//   NDIGITS  2  number of BCD digits per operand (>=1); operand width W = 4*NDIGITS
// PORTS
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous, active-high reset
//   start    in   1   request; sampled only in IDLE
//   A        in   W   minuend, packed BCD, digit i at [4i+3:4i]
//   B        in   W   subtrahend, packed BCD
//   Bin      in   1   borrow in
//   busy     out  1   high while in RUN
//   done     out  1   one-cycle pulse when D/Bout become valid
//   D        out  W   difference, packed BCD (ten's complement if negative)
//   Bout     out  1   borrow out; 1 when A < B + Bin
//   err      out  1   invalid-digit flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst=1 at posedge): state=IDLE; busy=0, done=0, D=0, Bout=0, err=0;
//     internal digit counter and operand registers cleared.
//   Reset mid-RUN: the operation is abandoned; no done pulse; outputs as above.
//   States:
//     IDLE -> RUN when start=1: latch A, B, Bin; counter=0; borrow=Bin.
//     RUN: per cycle, digit i=counter:
//       t = A_i - B_i - borrow (signed, 5 bit).
//       t<0: digit=t+10, borrow=1; else digit=t, borrow=0.
//       Write digit to D[4i+3:4i]; counter++.
//       After digit NDIGITS-1 -> DONE.
//     DONE (1 cycle): done=1; Bout=final borrow -> IDLE.
//   Latency: start high at edge n -> done high in cycle n+NDIGITS+1.
//   D and Bout are updated only at the end of RUN/DONE.
//     Held unchanged in IDLE until the next accepted start.
//     D bits not yet written in RUN keep their old value.
//   Input stability: A/B/Bin changes after the start edge have no effect.
//   start while busy=1 or done=1 is ignored (not queued).
//   Wrap: negative results give the ten's complement with Bout=1
//     (00-01 -> D=99, Bout=1).
//   Extremes: 00-99-1 -> D=00, Bout=1; 99-00-0 -> D=99, Bout=0.
//   Back-to-back: start held high continuously -> a new op is accepted
//     in the IDLE cycle following each DONE.
// CONFIGURATION
//   BCD_DIGIT_CHECK_EN defined:
//     Each latched digit of A and B is checked during RUN as it is processed.
//     Any digit >9 sets err; err is sticky until the next accepted start or rst.
//     The arithmetic still completes and D is unspecified when err=1.
//   BCD_DIGIT_CHECK_EN undefined:
//     err is tied 0; digits >9 are processed by the same rule with no flag.
// TESTING
//   A=99, B=99, Bin=0, start -> done after NDIGITS+1 cycles; D=00, Bout=0.
//   A=53, B=17, Bin=0 -> D=36, Bout=0.
//   A=50, B=25, Bin=1 -> D=24, Bout=0.
//   A=00, B=01, Bin=0 -> D=99, Bout=1.
//   A=12, B=12 in flight: pulse start again while busy, then pulse rst in RUN.
//     -> The second start is ignored.
//     -> After rst: no done pulse; D=00, Bout=0.
//     -> A subsequent op A=91, B=19 yields D=72.
//   With BCD_DIGIT_CHECK_EN: A=0xA1, B=01 -> err=1 at done.
//     The next start clears err; A=21, B=01 -> D=20, err=0.

Source files
------------

// File: rtl/bcd_serial_subtractor_if.sv
// Handshake and operand/result bundle for the digit-serial BCD subtractor.
// The requester drives start/A/B/Bin and observes busy/done/D/Bout/err.
interface bcd_serial_subtractor_if #(
  parameter int NDIGITS = 2
);
  logic                   start;
  logic [4*NDIGITS-1:0]   A;
  logic [4*NDIGITS-1:0]   B;
  logic                   Bin;
  logic                   busy;
  logic                   done;
  logic [4*NDIGITS-1:0]   D;
  logic                   Bout;
  logic                   err;

  modport master (
    output start, A, B, Bin,
    input  busy, done, D, Bout, err
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, Bout, err
  );
endinterface

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: D = A - B - Bin over NDIGITS packed BCD digits,
// one digit per clock, least-significant digit first. Negative results come
// out as the ten's complement with Bout=1. Result is held until the next
// accepted start.
// Optional feature: define BCD_DIGIT_CHECK_EN to flag operand digits >9 on
// err (sticky until the next accepted start or rst); otherwise err is tied 0.
module bcd_serial_subtractor #(
  parameter int NDIGITS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_serial_subtractor_if.slave io_bus
);

  localparam int W     = 4 * NDIGITS;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_d;
  logic               r_borrow;
  logic               r_bout;
  logic [4:0]         w_sub;
  logic [3:0]         w_dig;
  logic               w_borrow_nxt;

  // One BCD digit of subtraction: {borrow_out, digit}. A negative partial
  // difference is corrected by +10 and produces a borrow.
  function automatic logic [4:0] bcd_digit_sub(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       bi);
    logic signed [4:0] t;
    logic signed [4:0] tc;
    t  = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({4'b0000, bi});
    tc = t + 5'sd10;
    if (t < 0) return {1'b1, tc[3:0]};
    else       return {1'b0, t[3:0]};
  endfunction

  // Operands shift right so the digit being processed is always in [3:0].
  assign w_sub        = bcd_digit_sub(r_a[3:0], r_b[3:0], r_borrow);
  assign w_dig        = w_sub[3:0];
  assign w_borrow_nxt = w_sub[4];
  assign w_last       = (r_cnt == CNT_W'(NDIGITS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; start is only honoured in IDLE, never queued.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, digit loop, and result/borrow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_a      <= io_bus.A;
      r_b      <= io_bus.B;
      r_borrow <= io_bus.Bin;
    end else if (r_state == S_RUN) begin
      r_a                       <= r_a >> 4;
      r_b                       <= r_b >> 4;
      r_borrow                  <= w_borrow_nxt;
      r_d[4*int'(r_cnt) +: 4]   <= w_dig;
      r_cnt                     <= r_cnt + CNT_W'(1);
      if (w_last) r_bout <= w_borrow_nxt;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic r_err;
  logic w_bad_digit;

  assign w_bad_digit = (r_a[3:0] > 4'd9) || (r_b[3:0] > 4'd9);

  // Sticky invalid-digit flag, cleared when a new operation is accepted.
  always_ff @(posedge clk) begin
    if (rst)                                  r_err <= 1'b0;
    else if (w_accept)                        r_err <= 1'b0;
    else if (r_state == S_RUN && w_bad_digit) r_err <= 1'b1;
  end

  assign io_bus.err = r_err;
`else
  assign io_bus.err = 1'b0;
`endif

  assign io_bus.busy = (r_state == S_RUN);
  assign io_bus.done = (r_state == S_DONE);
  assign io_bus.D    = r_d;
  assign io_bus.Bout = r_bout;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed testbench for bcd_serial_subtractor (NDIGITS=2).
module tb_bcd_serial_subtractor;

  localparam int ND = 2;
  localparam int W  = 4 * ND;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  bcd_serial_subtractor_if #(.NDIGITS(ND)) bus ();

  bcd_serial_subtractor #(.NDIGITS(ND)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE and wait (bounded) for done.
  // lat = clock edges from the accepting edge to done, or -1 on timeout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic bin, output int lat);
    if (bus.done) step();
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    step();
    step();
    rst = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++; if (bus.D !== 8'h00) begin n_fail++; $display("FAIL reset_D got %h want 00", bus.D); end
    n_checks++; if (bus.Bout !== 1'b0) begin n_fail++; $display("FAIL reset_Bout got %b want 0", bus.Bout); end
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus.err); end
  endtask

  task automatic test_subtract();
    logic [W-1:0] va[6] = '{8'h99, 8'h53, 8'h50, 8'h00, 8'h00, 8'h99};
    logic [W-1:0] vb[6] = '{8'h99, 8'h17, 8'h25, 8'h01, 8'h99, 8'h00};
    logic         vi[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] ed[6] = '{8'h00, 8'h36, 8'h24, 8'h99, 8'h00, 8'h99};
    logic         eb[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int lat;
    for (int k = 0; k < 6; k++) begin
      run_op(va[k], vb[k], vi[k], lat);
      n_checks++;
      if (lat != ND) begin n_fail++; $display("FAIL sub%0d_latency got %0d want %0d", k, lat, ND); end
      n_checks++;
      if (bus.D !== ed[k]) begin n_fail++; $display("FAIL sub%0d_D %h-%h-%b got %h want %h", k, va[k], vb[k], vi[k], bus.D, ed[k]); end
      n_checks++;
      if (bus.Bout !== eb[k]) begin n_fail++; $display("FAIL sub%0d_Bout got %b want %b", k, bus.Bout, eb[k]); end
    end
  endtask

  // Inputs changed after acceptance must not matter; result holds in IDLE.
  task automatic test_hold_and_stability();
    int lat;
    if (bus.done) step();
    bus.A = 8'h53; bus.B = 8'h17; bus.Bin = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.A = 8'h00; bus.B = 8'h88; bus.Bin = 1'b1;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL stab_busy got %b want 1", bus.busy); end
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.done) begin lat = i; break; end
    end
    n_checks++; if (lat != ND) begin n_fail++; $display("FAIL stab_latency got %0d want %0d", lat, ND); end
    n_checks++; if (bus.D !== 8'h36) begin n_fail++; $display("FAIL stab_D got %h want 36", bus.D); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL hold_done cyc%0d got %b want 0", i, bus.done); end
      n_checks++; if (bus.D !== 8'h36) begin n_fail++; $display("FAIL hold_D cyc%0d got %h want 36", i, bus.D); end
    end
  endtask

  // start held through RUN is ignored and must not start a second op.
  task automatic test_ignore_start();
    int lat;
    if (bus.done) step();
    bus.A = 8'h12; bus.B = 8'h12; bus.Bin = 1'b0; bus.start = 1'b1;
    step();
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.done) begin lat = i; break; end
    end
    bus.start = 1'b0;
    n_checks++; if (lat != ND) begin n_fail++; $display("FAIL ign_latency got %0d want %0d", lat, ND); end
    n_checks++; if (bus.D !== 8'h00) begin n_fail++; $display("FAIL ign_D got %h want 00", bus.D); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL ign_idle cyc%0d got busy=%b done=%b want 0/0", i, bus.busy, bus.done); end
    end
  endtask

  task automatic test_rst_midrun();
    int lat;
    bit saw_done;
    run_op(8'h99, 8'h00, 1'b0, lat);
    step();
    bus.A = 8'h12; bus.B = 8'h12; bus.Bin = 1'b0; bus.start = 1'b1;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rstrun_busy got %b want 1", bus.busy); end
    n_checks++; if (bus.D !== 8'h90) begin n_fail++; $display("FAIL rstrun_partialD got %h want 90", bus.D); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rstrun_ctl got busy=%b done=%b want 0/0", bus.busy, bus.done); end
    n_checks++; if (bus.D !== 8'h00 || bus.Bout !== 1'b0) begin n_fail++; $display("FAIL rstrun_out got D=%h Bout=%b want 00/0", bus.D, bus.Bout); end
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rstrun_nodone got activity=%b want 0", saw_done); end
    run_op(8'h91, 8'h19, 1'b0, lat);
    n_checks++; if (lat != ND || bus.D !== 8'h72 || bus.Bout !== 1'b0) begin n_fail++; $display("FAIL after_rst_91_19 got lat=%0d D=%h Bout=%b want %0d/72/0", lat, bus.D, bus.Bout, ND); end
  endtask

  // start held high: new op accepted in the IDLE cycle after each DONE.
  task automatic test_back_to_back();
    int gap;
    int lat;
    step();
    bus.A = 8'h53; bus.B = 8'h17; bus.Bin = 1'b0; bus.start = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.done) begin lat = i; break; end
    end
    n_checks++; if (lat < 0 || bus.D !== 8'h36) begin n_fail++; $display("FAIL b2b_first got lat=%0d D=%h want done/36", lat, bus.D); end
    bus.A = 8'h91; bus.B = 8'h19;
    gap = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (bus.done) begin gap = i; break; end
    end
    bus.start = 1'b0;
    n_checks++; if (gap != ND + 2) begin n_fail++; $display("FAIL b2b_gap got %0d want %0d", gap, ND + 2); end
    n_checks++; if (bus.D !== 8'h72) begin n_fail++; $display("FAIL b2b_second_D got %h want 72", bus.D); end
  endtask

  task automatic test_digit_check();
    int lat;
`ifdef BCD_DIGIT_CHECK_EN
    run_op(8'hA1, 8'h01, 1'b0, lat);
    n_checks++; if (lat != ND || bus.err !== 1'b1) begin n_fail++; $display("FAIL chk_err_set got lat=%0d err=%b want %0d/1", lat, bus.err, ND); end
    run_op(8'h21, 8'h01, 1'b0, lat);
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL chk_err_clear got %b want 0", bus.err); end
    n_checks++; if (bus.D !== 8'h20) begin n_fail++; $display("FAIL chk_D got %h want 20", bus.D); end
`else
    run_op(8'hA1, 8'h01, 1'b0, lat);
    n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL nochk_err got %b want 0", bus.err); end
    n_checks++; if (bus.D !== 8'hA0 || bus.Bout !== 1'b0) begin n_fail++; $display("FAIL nochk_D got D=%h Bout=%b want A0/0", bus.D, bus.Bout); end
    run_op(8'h21, 8'h01, 1'b0, lat);
    n_checks++; if (bus.D !== 8'h20 || bus.err !== 1'b0) begin n_fail++; $display("FAIL nochk_21_01 got D=%h err=%b want 20/0", bus.D, bus.err); end
`endif
  endtask

  initial begin
    test_reset();
    test_subtract();
    test_hold_and_stability();
    test_ignore_start();
    test_rst_midrun();
    test_back_to_back();
    test_digit_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
